apb_m_bridge: RTL and testbench
===============================

# apb_m_bridge

Synthesizable APB3 master (initiator) converting a simple valid/ready command/response interface into single APB transfers. It is the RTL counterpart of our APB slave peripherals (e.g. the AES engine's APB slave port). It lets on-chip logic or a CPU-side adapter drive those peripherals in place of the APB master VIP. One transfer outstanding at a time, with an optional access timeout against hung slaves.

## Interface
Parameters:
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width
- TIMEOUT, 16, max ACCESS-phase cycles before forced abort; 0 disables timeout

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  bridge can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data (ignored for reads)
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_slverr  out  1  slave error or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- psel, penable, pwrite  out  1 each  APB control
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB slave ready
- pslverr  in  1  APB slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- cmd_ready = (state==IDLE) && !rsp_valid; combinational from registered state only.
- IDLE: on cmd_valid && cmd_ready, latch write/addr/wdata and go to SETUP.
- SETUP: psel=1, penable=0. Always exactly one cycle, then ACCESS.
- ACCESS: psel=1, penable=1. Wait-state counter clears on ACCESS entry and increments each ACCESS cycle with pready=0.
- pready=1 in ACCESS: capture rdata = pwrite ? 0 : prdata, slverr = pslverr, timeout = 0. Set rsp_valid and go to IDLE.
- TIMEOUT≠0 and counter reaches TIMEOUT with pready still 0: rsp_slverr=1, rsp_timeout=1, rsp_rdata=0, rsp_valid=1, go to IDLE. This deliberately deasserts psel mid-transfer.
- Response register holds until rsp_valid && rsp_ready; it then clears on that edge.
- pwrite/paddr/pwdata are registered. They are stable from SETUP through the end of ACCESS and retain their last values in IDLE (no toggling).
- Counter width is $clog2(TIMEOUT+1), minimum 1 bit.

## Timing
- Reset values: psel=penable=pwrite=0, paddr=pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_slverr=rsp_timeout=0, cmd_ready=1, state IDLE.
- Command accepted at edge k: SETUP during cycle k+1, ACCESS during k+2.
- Zero-wait slave: completion sampled at end of k+2; rsp_valid high during k+3. Latency is 3 cycles, plus N for N wait states.
- Timeout: abort sampled at the end of ACCESS cycle TIMEOUT+1 (TIMEOUT wait cycles). rsp_valid follows in the next cycle.
- Throughput: with rsp_ready tied high, the next command is accepted at the end of k+4, giving 4 cycles per zero-wait transfer.
- pslverr and prdata are sampled only in the cycle where penable && pready; they are ignored otherwise.
- pready=1 and the timeout threshold in the same cycle: pready wins, a normal completion with rsp_timeout=0.
- Reset asserted mid-transfer: psel/penable drop asynchronously, the pending response is discarded and the FSM returns to IDLE.

## Structure
- Package apb_m_bridge_pkg holds the state enum (IDLE/SETUP/ACCESS) and a packed response struct {rdata, slverr, timeout}.
- Single module, no sub-module; the timeout counter is inline.

## Test plan
- Write with zero wait: cmd addr=0x10, wdata=0xDEADBEEF. Expect psel in cycle 1, penable in cycle 2, pwrite=1 and paddr/pwdata stable; then rsp_valid with slverr=0 and rdata=0.
- Read with 3 wait states: slave returns prdata=0x12345678. Expect ACCESS held for 4 cycles, rsp_rdata=0x12345678, response latency 6 cycles.
- Slave error: read with pslverr=1 on completion. Expect rsp_slverr=1, rsp_timeout=0.
- Timeout, TIMEOUT=4, pready stuck at 0: expect psel to drop after 5 ACCESS cycles, then rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
- Backpressure: hold rsp_ready=0 for 10 cycles after a response. Expect cmd_ready=0 and no new psel until the response is consumed; with rsp_ready tied high, back-to-back commands are accepted every 4 cycles.
- Reset mid-ACCESS: expect psel, penable and rsp_valid at 0 immediately and cmd_ready=1 after release.

Source files
------------

// File: rtl/apb_m_bridge_pkg.sv
// Shared types for the APB3 master bridge: FSM state encoding and the
// response record captured at the end of each transfer.
package apb_m_bridge_pkg;

    // Width of the read-data field in the captured response record.
    // The bridge's DATA_W parameter defaults to this value.
    localparam int RSP_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    typedef struct packed {
        logic [RSP_DATA_W-1:0] rdata;
        logic                  slverr;
        logic                  timeout;
    } rsp_t;

endpackage

// File: rtl/apb_m_bridge.sv
// APB3 master: turns one valid/ready command into one APB transfer and
// returns a single response. One transfer in flight at a time; an optional
// wait-state timeout aborts transfers to a hung slave.
module apb_m_bridge
    import apb_m_bridge_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = RSP_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_slverr,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    // Counter must be able to hold the value TIMEOUT itself.
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   wait_cnt_reg;
    logic               pwrite_reg;
    logic [ADDR_W-1:0]  paddr_reg;
    logic [DATA_W-1:0]  pwdata_reg;
    rsp_t               rsp_reg;
    logic               rsp_valid_reg;

    logic accept;
    logic done;
    logic timeout_hit;
    logic abort;

    assign cmd_ready   = (state_reg == IDLE) && !rsp_valid_reg;
    assign accept      = cmd_valid && cmd_ready;
    assign done        = (state_reg == ACCESS) && pready;
    // Threshold reached with the slave still stalling; pready in the same
    // cycle takes priority so a late but valid completion is never lost.
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_reg == CNT_W'(TIMEOUT));
    assign abort       = (state_reg == ACCESS) && !pready && timeout_hit;

    // psel/penable decode straight from the state register so that reset
    // removes them asynchronously without an extra flop stage.
    assign psel        = (state_reg != IDLE);
    assign penable     = (state_reg == ACCESS);
    assign pwrite      = pwrite_reg;
    assign paddr       = paddr_reg;
    assign pwdata      = pwdata_reg;

    assign rsp_valid   = rsp_valid_reg;
    assign rsp_rdata   = DATA_W'(rsp_reg.rdata);
    assign rsp_slverr  = rsp_reg.slverr;
    assign rsp_timeout = rsp_reg.timeout;

    // Next-state decode for the SETUP/ACCESS sequence.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (done || abort) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Wait-state counter: zeroed while entering ACCESS, counts stalled cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == SETUP) begin
            wait_cnt_reg <= '0;
        end else if ((state_reg == ACCESS) && !pready) begin
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
        end
    end

    // APB request fields: loaded on command accept, held otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwrite_reg <= 1'b0;
            paddr_reg  <= '0;
            pwdata_reg <= '0;
        end else if (accept) begin
            pwrite_reg <= cmd_write;
            paddr_reg  <= cmd_addr;
            pwdata_reg <= cmd_wdata;
        end
    end

    // Response register: captured on completion or abort, cleared on handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_reg       <= '0;
            rsp_valid_reg <= 1'b0;
        end else if (done) begin
            rsp_reg.rdata   <= pwrite_reg ? '0 : RSP_DATA_W'(prdata);
            rsp_reg.slverr  <= pslverr;
            rsp_reg.timeout <= 1'b0;
            rsp_valid_reg   <= 1'b1;
        end else if (abort) begin
            rsp_reg.rdata   <= '0;
            rsp_reg.slverr  <= 1'b1;
            rsp_reg.timeout <= 1'b1;
            rsp_valid_reg   <= 1'b1;
        end else if (rsp_valid_reg && rsp_ready) begin
            rsp_reg       <= '0;
            rsp_valid_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_apb_m_bridge.sv
// Self-checking bench for apb_m_bridge with a small APB slave model whose
// wait states, error and read data are set per transfer.
module tb_apb_m_bridge;

    localparam int TO = 4;
    localparam time PERIOD = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_timeout;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    int errors = 0;
    int checks = 0;

    // Slave behaviour for the current transfer
    int          slave_waits = 0;
    logic        slave_err = 1'b0;
    logic [31:0] slave_rdata = '0;
    int          acc_cycles = 0;

    typedef struct {
        int          latency;
        int          setups;
        int          accesses;
        bit          stable;
        logic [31:0] rdata;
        logic        slverr;
        logic        timeout;
        time         accept_t;
    } obs_t;

    typedef struct {
        int          latency;
        int          accesses;
        logic [31:0] rdata;
        logic        slverr;
        logic        timeout;
    } exp_t;

    apb_m_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #(PERIOD/2) clk = ~clk;

    // APB slave: raises pready in ACCESS cycle slave_waits+1; prdata and
    // pslverr carry junk in every cycle where pready is low.
    always @(negedge clk) begin
        if (psel && penable) begin
            pready = (acc_cycles == slave_waits);
            prdata = pready ? slave_rdata : $urandom;
            pslverr = pready ? slave_err : 1'($urandom);
            acc_cycles++;
        end else begin
            pready = 1'b0;
            prdata = $urandom;
            pslverr = 1'($urandom);
            acc_cycles = 0;
        end
    end

    // Reference: a transfer stalled for more than TO wait states is aborted
    // after TO waits; otherwise it completes after its own wait count.
    function automatic exp_t model(input logic wr, input int waits,
                                   input logic serr, input logic [31:0] rd);
        exp_t e;
        bit to_hit = (waits > TO);
        int eff = to_hit ? TO : waits;
        e.latency  = 3 + eff;
        e.accesses = eff + 1;
        e.rdata    = (to_hit || wr) ? 32'h0 : rd;
        e.slverr   = to_hit ? 1'b1 : serr;
        e.timeout  = to_hit;
        return e;
    endfunction

    // Drives one command, watches the APB side, returns what was observed.
    // Called 1 time unit after a rising edge; returns in the same phase.
    task automatic run_xfer(input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int waits,
                            input logic serr, input logic [31:0] rd,
                            output obs_t o);
        int n;
        o.latency = -1; o.setups = 0; o.accesses = 0; o.stable = 1;
        o.rdata = 'x; o.slverr = 'x; o.timeout = 'x; o.accept_t = 0;
        slave_waits = waits; slave_err = serr; slave_rdata = rd;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        o.accept_t = $time;
        #1;
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (psel && !penable) o.setups++;
            if (psel && penable) o.accesses++;
            if (psel && (paddr !== addr || pwdata !== wdata || pwrite !== wr)) o.stable = 0;
            if (rsp_valid) begin
                o.latency = c; o.rdata = rsp_rdata; o.slverr = rsp_slverr; o.timeout = rsp_timeout;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({psel, penable, pwrite} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got=%b want=000", {psel, penable, pwrite}); end
        checks++; if (paddr !== 32'h0 || pwdata !== 32'h0) begin errors++; $display("FAIL reset_bus paddr=%h pwdata=%h want=0", paddr, pwdata); end
        checks++; if ({rsp_valid, rsp_slverr, rsp_timeout} !== 3'b000 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp got v/e/t=%b rdata=%h want 000/0", {rsp_valid, rsp_slverr, rsp_timeout}, rsp_rdata); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        $display("test_reset done");
    endtask

    task automatic check_xfer(input string name, input obs_t o, input exp_t e);
        checks++;
        if (o.latency !== e.latency || o.accesses !== e.accesses || o.setups !== 1 ||
            o.stable !== 1'b1 || o.rdata !== e.rdata || o.slverr !== e.slverr || o.timeout !== e.timeout) begin
            errors++;
            $display("FAIL %s got lat=%0d acc=%0d setup=%0d stable=%0d rdata=%h err=%b to=%b want lat=%0d acc=%0d setup=1 stable=1 rdata=%h err=%b to=%b",
                     name, o.latency, o.accesses, o.setups, o.stable, o.rdata, o.slverr, o.timeout,
                     e.latency, e.accesses, e.rdata, e.slverr, e.timeout);
        end
    endtask

    task automatic test_write_zero_wait();
        obs_t o;
        run_xfer(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, 32'hCAFEF00D, o);
        checks++; if (o.latency !== 3) begin errors++; $display("FAIL wr_latency got=%0d want=3", o.latency); end
        checks++; if (o.rdata !== 32'h0 || o.slverr !== 1'b0) begin errors++; $display("FAIL wr_rsp rdata=%h err=%b want 0/0", o.rdata, o.slverr); end
        checks++; if (o.stable !== 1'b1 || o.setups !== 1 || o.accesses !== 1) begin errors++; $display("FAIL wr_phases stable=%0d setup=%0d acc=%0d want 1/1/1", o.stable, o.setups, o.accesses); end
        checks++; if (paddr !== 32'h10 || pwdata !== 32'hDEADBEEF || pwrite !== 1'b1) begin errors++; $display("FAIL wr_idle_hold paddr=%h pwdata=%h pwrite=%b", paddr, pwdata, pwrite); end
        $display("test_write_zero_wait lat=%0d", o.latency);
    endtask

    task automatic test_read_wait();
        obs_t o;
        run_xfer(1'b0, 32'h24, 32'h0, 3, 1'b0, 32'h12345678, o);
        checks++; if (o.latency !== 6 || o.accesses !== 4) begin errors++; $display("FAIL rd_wait_timing lat=%0d acc=%0d want 6/4", o.latency, o.accesses); end
        checks++; if (o.rdata !== 32'h12345678 || o.slverr !== 1'b0 || o.timeout !== 1'b0) begin errors++; $display("FAIL rd_wait_rsp rdata=%h err=%b to=%b want 12345678/0/0", o.rdata, o.slverr, o.timeout); end
        $display("test_read_wait lat=%0d rdata=%h", o.latency, o.rdata);
    endtask

    task automatic test_slverr();
        obs_t o;
        run_xfer(1'b0, 32'h30, 32'h0, 1, 1'b1, 32'h55AA55AA, o);
        check_xfer("slverr", o, model(1'b0, 1, 1'b1, 32'h55AA55AA));
        checks++; if (o.slverr !== 1'b1 || o.timeout !== 1'b0) begin errors++; $display("FAIL slverr_flags err=%b to=%b want 1/0", o.slverr, o.timeout); end
        $display("test_slverr err=%b to=%b", o.slverr, o.timeout);
    endtask

    task automatic test_timeout();
        obs_t o;
        run_xfer(1'b0, 32'h40, 32'h0, 1000, 1'b0, 32'hFFFFFFFF, o);
        checks++; if (o.accesses !== TO + 1 || o.latency !== TO + 3) begin errors++; $display("FAIL timeout_timing acc=%0d lat=%0d want %0d/%0d", o.accesses, o.latency, TO + 1, TO + 3); end
        checks++; if (o.slverr !== 1'b1 || o.timeout !== 1'b1 || o.rdata !== 32'h0) begin errors++; $display("FAIL timeout_rsp err=%b to=%b rdata=%h want 1/1/0", o.slverr, o.timeout, o.rdata); end
        $display("test_timeout acc=%0d", o.accesses);
        // pready exactly at the threshold cycle: normal completion
        run_xfer(1'b0, 32'h44, 32'h0, TO, 1'b0, 32'hA5A5A5A5, o);
        check_xfer("threshold_pready", o, model(1'b0, TO, 1'b0, 32'hA5A5A5A5));
        $display("test_timeout threshold to=%b rdata=%h", o.timeout, o.rdata);
    endtask

    task automatic test_random();
        obs_t o;
        for (int i = 0; i < 24; i++) begin
            logic wr = 1'($urandom);
            logic [31:0] a = $urandom, wd = $urandom, rd = $urandom;
            int w = $urandom_range(0, TO + 2);
            logic se = 1'($urandom);
            run_xfer(wr, a, wd, w, se, rd, o);
            check_xfer("random", o, model(wr, w, se, rd));
            $display("random #%0d wr=%b addr=%h waits=%0d lat=%0d rdata=%h err=%b to=%b", i, wr, a, w, o.latency, o.rdata, o.slverr, o.timeout);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        time prev = 0;
        for (int i = 0; i < 4; i++) begin
            run_xfer(1'b1, 32'h100 + 32'(i * 4), $urandom, 0, 1'b0, 32'h0, o);
            if (i > 0) begin
                checks++;
                if (o.accept_t - prev !== 4 * PERIOD) begin errors++; $display("FAIL b2b_spacing got=%0t want=%0t", o.accept_t - prev, 4 * PERIOD); end
            end
            prev = o.accept_t;
            $display("back_to_back #%0d accept_t=%0t", i, o.accept_t);
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        bit bad = 0;
        rsp_ready = 1'b0;
        run_xfer(1'b0, 32'h80, 32'h0, 0, 1'b0, 32'h0BADF00D, o);
        check_xfer("bp_rsp", o, model(1'b0, 0, 1'b0, 32'h0BADF00D));
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h84;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (cmd_ready !== 1'b0 || psel !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BADF00D) bad = 1;
        end
        checks++; if (bad) begin errors++; $display("FAIL bp_hold cmd_ready=%b psel=%b rsp_valid=%b rdata=%h want 0/0/1/0badf00d", cmd_ready, psel, rsp_valid, rsp_rdata); end
        @(posedge clk); #1;
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || psel !== 1'b0) begin errors++; $display("FAIL bp_release rsp_valid=%b cmd_ready=%b psel=%b want 0/1/0", rsp_valid, cmd_ready, psel); end
        $display("test_backpressure released");
    endtask

    task automatic test_reset_mid_access();
        slave_waits = 3; slave_err = 1'b0; slave_rdata = 32'h77;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'hC0;
        @(posedge clk); #1;            // accepted; SETUP
        cmd_valid = 1'b0;
        @(posedge clk); #1;            // ACCESS
        checks++; if (!(psel && penable)) begin errors++; $display("FAIL rst_mid_pre psel=%b penable=%b want 1/1", psel, penable); end
        reset = 1'b1;
        #1;
        checks++; if ({psel, penable, rsp_valid} !== 3'b000) begin errors++; $display("FAIL rst_mid_async got=%b want=000", {psel, penable, rsp_valid}); end
        @(negedge clk); reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || psel !== 1'b0) begin errors++; $display("FAIL rst_mid_after cmd_ready=%b rsp_valid=%b psel=%b want 1/0/0", cmd_ready, rsp_valid, psel); end
        $display("test_reset_mid_access done");
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
